// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv
// rtl/firebird7_in_gate1_tessent_data_mux_ctrl_if.sv - TDR/functional-side bundle for the IJTAG data-override mux controller
interface firebird7_in_gate1_tessent_data_mux_ctrl_if #(
  parameter int WIDTH = 3
);
  logic             override_req;
  logic [WIDTH-1:0] shadow_data;
  logic             shadow_update;
  logic             func_quiet;
  logic             func_hold;
  logic             ijtag_select;
  logic [WIDTH-1:0] ijtag_data_out;
  logic             override_ack;
  logic             busy;
  logic             timeout_err;

  modport master (
    output override_req, shadow_data, shadow_update, func_quiet,
    input  func_hold, ijtag_select, ijtag_data_out, override_ack, busy, timeout_err
  );

  modport slave (
    input  override_req, shadow_data, shadow_update, func_quiet,
    output func_hold, ijtag_select, ijtag_data_out, override_ack, busy, timeout_err
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv - IJTAG data-override mux sequencer with quiesce handshake and settle guards
// Optional quiesce timeout: DATA_MUX_CTRL_QUIET_TIMEOUT_EN.
module firebird7_in_gate1_tessent_data_mux_ctrl #(
  parameter int WIDTH          = 3,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic ijtag_tck,
  input  logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_ctrl_if.slave bus
);

  localparam int MAXC = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_QUIET, SETTLE_IN, ACTIVE, SETTLE_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    shadow_d = bus.shadow_update ? bus.shadow_data : shadow_q;

    if (err_q && !bus.override_req) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.override_req && !err_q) begin
          state_d = WAIT_QUIET;
`ifdef DATA_MUX_CTRL_QUIET_TIMEOUT_EN
          cnt_d   = CW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      WAIT_QUIET: begin
        // Abort outranks func_quiet, which in turn outranks an expiring timeout.
        if (!bus.override_req) begin
          state_d = IDLE;
        end else if (bus.func_quiet) begin
          state_d = SETTLE_IN;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end
`ifdef DATA_MUX_CTRL_QUIET_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`endif
      end
      SETTLE_IN: begin
        if (!bus.override_req) begin
          state_d = SETTLE_OUT;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACTIVE: begin
        if (!bus.override_req) begin
          state_d = SETTLE_OUT;
          cnt_d   = CW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE_OUT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase

`ifndef DATA_MUX_CTRL_QUIET_TIMEOUT_EN
    err_d = 1'b0;
`endif

    // Outputs are decoded from the next state so they change on the transition edge.
    hold_d = (state_d != IDLE);
    busy_d = (state_d != IDLE);
    sel_d  = (state_d == ACTIVE);
  end

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      hold_q   <= 1'b0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.func_hold      = hold_q;
  assign bus.ijtag_select   = sel_q;
  assign bus.override_ack   = sel_q;
  assign bus.busy           = busy_q;
  assign bus.ijtag_data_out = shadow_q;
`ifdef DATA_MUX_CTRL_QUIET_TIMEOUT_EN
  assign bus.timeout_err    = err_q;
`else
  assign bus.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv - directed self-checking bench for the data-override mux controller
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  firebird7_in_gate1_tessent_data_mux_ctrl_if #(.WIDTH(3)) bus ();

  firebird7_in_gate1_tessent_data_mux_ctrl #(
    .WIDTH(3), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst),
    .bus         (bus)
  );

  // {func_hold, ijtag_select, override_ack, busy, timeout_err}
  logic [4:0] st;
  assign st = {bus.func_hold, bus.ijtag_select, bus.override_ack, bus.busy, bus.timeout_err};

  localparam logic [4:0] S_IDLE = 5'b00000;
  localparam logic [4:0] S_HOLD = 5'b10010;
  localparam logic [4:0] S_ACT  = 5'b11110;
  localparam logic [4:0] S_ERR  = 5'b00001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_active();
    bus.override_req = 1'b1;
    bus.func_quiet   = 1'b1;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.override_req = 1'b0; bus.shadow_data = 3'b111; bus.shadow_update = 1'b1; bus.func_quiet = 1'b0;
    step(); step();
    bus.shadow_update = 1'b0;
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL reset_status: got %b expected %b", st, S_IDLE); end
    n_cmp++;
    if (bus.ijtag_data_out !== 3'b000) begin n_fail++; $display("FAIL reset_data: got %b expected %b", bus.ijtag_data_out, 3'b000); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (st !== S_IDLE) begin n_fail++; $display("FAIL idle_hold[%0d]: got %b expected %b", i, st, S_IDLE); end
    end
  endtask

  task automatic test_nominal();
    bus.shadow_data = 3'b101; bus.shadow_update = 1'b1;
    step();
    bus.shadow_update = 1'b0;
    n_cmp++;
    if (bus.ijtag_data_out !== 3'b101) begin n_fail++; $display("FAIL preload_data: got %b expected %b", bus.ijtag_data_out, 3'b101); end
    bus.override_req = 1'b1;
    step();
    n_cmp++;
    if (st !== S_HOLD) begin n_fail++; $display("FAIL nom_edge1: got %b expected %b", st, S_HOLD); end
    step();
    bus.func_quiet = 1'b1;
    step();
    n_cmp++;
    if (st !== S_HOLD) begin n_fail++; $display("FAIL nom_edge3: got %b expected %b", st, S_HOLD); end
    for (int e = 4; e <= 7; e++) begin
      step();
      n_cmp++;
      if (st !== ((e == 7) ? S_ACT : S_HOLD)) begin
        n_fail++; $display("FAIL nom_edge%0d: got %b expected %b", e, st, (e == 7) ? S_ACT : S_HOLD);
      end
      n_cmp++;
      if (bus.ijtag_data_out !== 3'b101) begin n_fail++; $display("FAIL nom_data_edge%0d: got %b expected %b", e, bus.ijtag_data_out, 3'b101); end
    end
    bus.shadow_data = 3'b010; bus.shadow_update = 1'b1; bus.func_quiet = 1'b0;
    step();
    bus.shadow_update = 1'b0;
    n_cmp++;
    if (bus.ijtag_data_out !== 3'b010) begin n_fail++; $display("FAIL active_update: got %b expected %b", bus.ijtag_data_out, 3'b010); end
    n_cmp++;
    if (st !== S_ACT) begin n_fail++; $display("FAIL quiet_drop_ignored: got %b expected %b", st, S_ACT); end
    bus.override_req = 1'b0;
    step();
    n_cmp++;
    if (st !== S_HOLD) begin n_fail++; $display("FAIL release_edge: got %b expected %b", st, S_HOLD); end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (st !== ((i == 4) ? S_IDLE : S_HOLD)) begin
        n_fail++; $display("FAIL settle_out%0d: got %b expected %b", i, st, (i == 4) ? S_IDLE : S_HOLD);
      end
    end
  endtask

  task automatic test_abort_wait_quiet();
    bus.override_req = 1'b1; bus.func_quiet = 1'b0;
    step();
    bus.override_req = 1'b0; bus.func_quiet = 1'b1;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL abort_wq: got %b expected %b", st, S_IDLE); end
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (bus.ijtag_select !== 1'b0) begin n_fail++; $display("FAIL abort_wq_sel[%0d]: got %b expected 0", i, bus.ijtag_select); end
    end
    bus.func_quiet = 1'b0;
  endtask

  task automatic test_abort_settle_in();
    bus.override_req = 1'b1; bus.func_quiet = 1'b1;
    step(); step();
    bus.override_req = 1'b0;
    step();
    n_cmp++;
    if (st !== S_HOLD) begin n_fail++; $display("FAIL abort_si_edge: got %b expected %b", st, S_HOLD); end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++;
      if (st !== ((i == 4) ? S_IDLE : S_HOLD)) begin
        n_fail++; $display("FAIL abort_si_out%0d: got %b expected %b", i, st, (i == 4) ? S_IDLE : S_HOLD);
      end
    end
    bus.func_quiet = 1'b0;
  endtask

  task automatic test_reset_in_active();
    go_active();
    n_cmp++;
    if (st !== S_ACT) begin n_fail++; $display("FAIL pre_reset_active: got %b expected %b", st, S_ACT); end
    rst = 1'b1;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL reset_active: got %b expected %b", st, S_IDLE); end
    rst = 1'b0; bus.override_req = 1'b0; bus.func_quiet = 1'b0;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL post_reset_idle: got %b expected %b", st, S_IDLE); end
  endtask

  task automatic test_timeout();
    bus.override_req = 1'b1; bus.func_quiet = 1'b0;
    step();
`ifdef DATA_MUX_CTRL_QUIET_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      n_cmp++;
      if (st !== ((i == 8) ? S_ERR : S_HOLD)) begin
        n_fail++; $display("FAIL timeout_wq%0d: got %b expected %b", i, st, (i == 8) ? S_ERR : S_HOLD);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (st !== S_ERR) begin n_fail++; $display("FAIL timeout_block[%0d]: got %b expected %b", i, st, S_ERR); end
    end
    bus.override_req = 1'b0;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL timeout_clear: got %b expected %b", st, S_IDLE); end
    bus.override_req = 1'b1;
    step();
    n_cmp++;
    if (st !== S_HOLD) begin n_fail++; $display("FAIL timeout_rerequest: got %b expected %b", st, S_HOLD); end
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      n_cmp++;
      if (st !== S_HOLD) begin n_fail++; $display("FAIL wait_forever%0d: got %b expected %b", i, st, S_HOLD); end
    end
`endif
    bus.override_req = 1'b0;
    step();
    n_cmp++;
    if (st !== S_IDLE) begin n_fail++; $display("FAIL timeout_exit: got %b expected %b", st, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_abort_wait_quiet();
    test_abort_settle_in();
    test_reset_in_active();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
